// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule constants, round constants and FSM state type
package aes_pkg;

   localparam int AES128_NR = 10;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } kexp_state_e;

   // Rcon[i] is the leading byte of the round constant word; index 0 is unused.
   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] value;
      case (round)
         4'd1:    value = 8'h01;
         4'd2:    value = 8'h02;
         4'd3:    value = 8'h04;
         4'd4:    value = 8'h08;
         4'd5:    value = 8'h10;
         4'd6:    value = 8'h20;
         4'd7:    value = 8'h40;
         4'd8:    value = 8'h80;
         4'd9:    value = 8'h1b;
         4'd10:   value = 8'h36;
         default: value = 8'h00;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte in, one byte out
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   // Entry n occupies bits [8n +: 8] with the MSB at the lowest bit index.
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_o = SBOX[{in_i, 3'b000} +: 8];

endmodule

// File: rtl/round_key_gen.sv
// rtl/round_key_gen.sv - iterative AES-128 key expansion into an 11-entry round-key store
module round_key_gen
   import aes_pkg::*;
#(
   parameter int NR = AES128_NR
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [0:127] key_in,
   input  logic         key_load,
   input  logic [3:0]   rk_idx,
   output logic [0:127] rk_out,
   output logic         busy,
   output logic         keys_valid
);

   localparam logic [3:0] LAST = 4'(NR);

   kexp_state_e  state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [0:127] rk_q [0:NR];
   logic [0:127] rk_out_q, rk_out_d;
   logic [0:127] prev_key, next_key;
   logic [0:31]  rot_word, sub_word;
   logic [0:31]  w0, w1, w2, w3;
   logic         start;

   // A load is only honoured outside EXPAND so an expansion always runs to completion.
   assign start = key_load && (state_q != EXPAND);

   // Single word-transform datapath, fed from the previously written round key.
   assign prev_key = rk_q[cnt_q - 4'd1];
   assign rot_word = {prev_key[104:127], prev_key[96:103]};

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (rot_word[8*b +: 8]),
         .out_o (sub_word[8*b +: 8])
      );
   end

   assign w0       = prev_key[0:31]  ^ sub_word ^ {rcon(cnt_q), 24'h000000};
   assign w1       = prev_key[32:63] ^ w0;
   assign w2       = prev_key[64:95] ^ w1;
   assign w3       = prev_key[96:127] ^ w2;
   assign next_key = {w0, w1, w2, w3};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (key_load) state_d = EXPAND;
         EXPAND:  if (cnt_q == LAST) state_d = DONE;
         DONE:    if (key_load) state_d = EXPAND;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q == EXPAND);
      keys_valid = (state_q == DONE);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = 4'd1;
      end else if ((state_q == EXPAND) && (cnt_q < LAST)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Key storage carries no reset; its contents only matter once keys_valid is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (start) begin
            rk_q[0] <= key_in;
         end else if (state_q == EXPAND) begin
            rk_q[cnt_q] <= next_key;
         end
      end
   end

   always_comb begin
      rk_out_d = '0;
      if (rk_idx <= LAST) begin
         rk_out_d = rk_q[rk_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rk_out_q <= '0;
      end else begin
         rk_out_q <= rk_out_d;
      end
   end

   assign rk_out = rk_out_q;

endmodule

// File: tb/tb_round_key_gen.sv
// tb/tb_round_key_gen.sv - directed self-checking bench for round_key_gen
module tb_round_key_gen;

   logic         clk;
   logic         rst;
   logic [0:127] key_in;
   logic         key_load;
   logic [3:0]   rk_idx;
   logic [0:127] rk_out;
   logic         busy;
   logic         keys_valid;

   int n_cmp;
   int n_err;

   logic [127:0] fips_rk [0:10];
   logic [127:0] zero_rk1;
   logic [127:0] zero_rk10;

   round_key_gen #(.NR(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in),
      .key_load   (key_load),
      .rk_idx     (rk_idx),
      .rk_out     (rk_out),
      .busy       (busy),
      .keys_valid (keys_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Call right after the load edge; key_load may be re-pulsed on edge pulse_at (0 = never).
   task automatic run_expansion(input string tag, input int pulse_at, input logic [127:0] pulse_key);
      for (int k = 1; k <= 9; k++) begin
         key_load = (k == pulse_at);
         if (k == pulse_at) key_in = pulse_key;
         tick();
         check({tag, "_kv_low"}, 128'(keys_valid), 128'd0);
         check({tag, "_busy_high"}, 128'(busy), 128'd1);
      end
      key_load = 1'b0;
      tick();
      check({tag, "_kv_rise"}, 128'(keys_valid), 128'd1);
      check({tag, "_busy_low"}, 128'(busy), 128'd0);
   endtask

   task automatic read_rk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
      rk_idx = idx;
      tick();
      check(tag, rk_out, exp);
   endtask

   task automatic load_key(input string tag, input logic [127:0] key);
      key_in   = key;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      check({tag, "_load_busy"}, 128'(busy), 128'd1);
      check({tag, "_load_kv"}, 128'(keys_valid), 128'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      zero_rk1    = 128'h62636363626363636263636362636363;
      zero_rk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

      rst      = 1'b1;
      key_in   = '0;
      key_load = 1'b0;
      rk_idx   = 4'd0;
      tick();
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_kv", 128'(keys_valid), 128'd0);
      check("reset_rk_out", rk_out, 128'd0);

      // Reset wins over a simultaneous load.
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      check("rst_prio_busy", 128'(busy), 128'd0);
      rst = 1'b0;
      read_rk("idle_oob_idx", 4'd12, 128'd0);

      load_key("fips", fips_rk[0]);
      run_expansion("fips", 0, '0);
      for (int i = 0; i <= 15; i++) begin
         read_rk($sformatf("sweep_rk%0d", i), 4'(i), (i <= 10) ? fips_rk[i] : 128'd0);
      end
      check("sweep_kv_held", 128'(keys_valid), 128'd1);

      load_key("zero", 128'd0);
      run_expansion("zero", 0, '0);
      read_rk("zero_rk1", 4'd1, zero_rk1);
      read_rk("zero_rk10", 4'd10, zero_rk10);
      read_rk("zero_rk0", 4'd0, 128'd0);

      load_key("ignore", fips_rk[0]);
      run_expansion("ignore", 4, {128{1'b1}});
      read_rk("ignore_rk0", 4'd0, fips_rk[0]);
      read_rk("ignore_rk1", 4'd1, fips_rk[1]);
      read_rk("ignore_rk10", 4'd10, fips_rk[10]);

      rk_idx = 4'd10;
      load_key("abort", 128'd0);
      for (int k = 1; k <= 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_kv", 128'(keys_valid), 128'd0);
      check("abort_rk_out", rk_out, 128'd0);
      for (int k = 0; k < 12; k++) begin
         tick();
         check("abort_kv_stays_low", 128'(keys_valid), 128'd0);
      end

      load_key("reload", fips_rk[0]);
      run_expansion("reload", 0, '0);
      read_rk("reload_rk1", 4'd1, fips_rk[1]);
      read_rk("reload_rk10", 4'd10, fips_rk[10]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
